// File: rtl/clk_freq_monitor.sv
// Probe clock frequency monitor: counts synchronized probe edges per
// reference window and flags out-of-tolerance frequencies.
module clk_freq_monitor #(
   parameter int WINDOW = 960,
   parameter int EXPECT = 160,
   parameter int TOL    = 2,
   parameter int CNT_W  = 12,
   parameter int GOOD_N = 2
) (
   input  logic             clk_96M,
   input  logic             n_reset,
   input  logic             clk_probe,
   input  logic             enable,
   input  logic             clear_fault,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             freq_ok,
   output logic             fault
);

   localparam int IDX_W  = $clog2(WINDOW);
   localparam int STK_W  = $clog2(GOOD_N + 1);
   localparam int MAXV   = (2 ** (CNT_W + 1)) - 1;
   localparam int LO_RAW = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
   localparam int HI_RAW = EXPECT + TOL;
   localparam int LO_C   = (LO_RAW > MAXV) ? MAXV : LO_RAW;
   localparam int HI_C   = (HI_RAW > MAXV) ? MAXV : HI_RAW;

   localparam logic [CNT_W:0]     LO_B     = LO_C[CNT_W:0];
   localparam logic [CNT_W:0]     HI_B     = HI_C[CNT_W:0];
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(WINDOW - 1);
   localparam logic [STK_W-1:0]   STK_MAX  = STK_W'(GOOD_N);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE
   } state_t;

   state_t           r_state;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic [1:0]       r_settle;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_count;
   logic             r_valid;
   logic [STK_W-1:0] r_streak;
   logic             r_freq_ok;
   logic             r_fault;

   logic             w_edge;
   logic             w_last;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_final;
   logic [CNT_W:0]   w_fin_x;
   logic             w_in_tol;
   logic [STK_W-1:0] w_stk_next;

   // The probe is plain asynchronous data here, never a clock.
   always_ff @(posedge clk_96M or negedge n_reset) begin
      if (!n_reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= clk_probe;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge    = r_sync2 & ~r_prev;
   assign w_last    = (r_state == S_MEASURE) && (r_idx == IDX_LAST);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
   assign w_final   = w_edge ? w_cnt_inc : r_cnt;
   assign w_fin_x   = {1'b0, w_final};
   assign w_in_tol  = (w_fin_x >= LO_B) && (w_fin_x <= HI_B);

   always_comb begin
      w_stk_next = '0;
      if (w_in_tol) begin
         if (r_streak == STK_MAX) begin
            w_stk_next = r_streak;
         end else begin
            w_stk_next = r_streak + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_96M or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= S_IDLE;
         r_settle  <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_streak  <= '0;
         r_freq_ok <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         // A bad window later in this block overrides the clear.
         if (clear_fault) begin
            r_fault <= 1'b0;
         end
         if (!enable) begin
            r_state   <= S_IDLE;
            r_settle  <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_streak  <= '0;
            r_freq_ok <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_state  <= S_SETTLE;
                  r_settle <= '0;
               end
               S_SETTLE: begin
                  if (r_settle == 2'd3) begin
                     r_state <= S_MEASURE;
                     r_idx   <= '0;
                     r_cnt   <= '0;
                  end else begin
                     r_settle <= r_settle + 1'b1;
                  end
               end
               S_MEASURE: begin
                  if (w_last) begin
                     r_idx     <= '0;
                     r_cnt     <= w_edge ? CNT_ONE : '0;
                     r_count   <= w_final;
                     r_valid   <= 1'b1;
                     r_streak  <= w_stk_next;
                     r_freq_ok <= (w_stk_next == STK_MAX);
                     if (!w_in_tol) begin
                        r_fault <= 1'b1;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     r_cnt <= w_final;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign count   = r_count;
   assign valid   = r_valid;
   assign freq_ok = r_freq_ok;
   assign fault   = r_fault;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor with a per-window scoreboard.
module tb_clk_freq_monitor;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        clk_probe = 1'b0;
   logic        enable = 1'b0;
   logic        clear_fault = 1'b0;
   logic [11:0] count;
   logic        valid;
   logic        freq_ok;
   logic        fault;
   logic [5:0]  s_count;
   logic        s_valid;
   logic        s_freq_ok;
   logic        s_fault;

   int   half = 3;
   logic stuck = 1'b0;
   int   ph = 0;
   int   tests = 0;
   int   fails = 0;
   int   n;
   logic seen;

   typedef struct {
      int lo;
      int hi;
      int ok;
      int flt;
      int sat;
   } exp_t;

   exp_t sb[$];

   clk_freq_monitor #(
      .WINDOW(960), .EXPECT(160), .TOL(2), .CNT_W(12), .GOOD_N(2)
   ) u_dut (
      .clk_96M(clk), .n_reset(n_reset), .clk_probe(clk_probe),
      .enable(enable), .clear_fault(clear_fault),
      .count(count), .valid(valid), .freq_ok(freq_ok), .fault(fault)
   );

   clk_freq_monitor #(
      .WINDOW(960), .EXPECT(160), .TOL(2), .CNT_W(6), .GOOD_N(2)
   ) u_sat (
      .clk_96M(clk), .n_reset(n_reset), .clk_probe(clk_probe),
      .enable(enable), .clear_fault(clear_fault),
      .count(s_count), .valid(s_valid), .freq_ok(s_freq_ok), .fault(s_fault)
   );

   always #5 clk = ~clk;

   // half = reference cycles per probe half-period; 0 = stuck
   always @(negedge clk) begin
      if (half == 0) begin
         clk_probe = stuck;
      end else begin
         ph = ph + 1;
         if (ph >= half) begin
            ph = 0;
            clk_probe = ~clk_probe;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs,
                          input int lo, input int hi);
      tests++;
      assert ((obs >= lo && obs <= hi) === 1'b1) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic push(input int lo, input int hi, input int ok,
                       input int flt, input int sat);
      exp_t e;
      e = '{lo, hi, ok, flt, sat};
      sb.push_back(e);
   endtask

   task automatic wait_valid(output int cyc);
      logic got;
      exp_t e;
      got = 1'b0;
      cyc = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("valid_seen", got, 1);
      if (got) begin
         chk("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.lo >= 0) chk_rng("count", count, e.lo, e.hi);
            if (e.ok >= 0) chk("freq_ok", freq_ok, e.ok);
            if (e.flt >= 0) chk("fault", fault, e.flt);
            if (e.sat >= 0) begin
               chk("sat_valid", s_valid, 1);
               chk("sat_count", s_count, e.sat);
               chk("sat_fault", s_fault, 1);
            end
         end
      end
   endtask

   initial begin
      enable = 1'b1;
      half = 3;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_freq_ok", freq_ok, 0);
      chk("rst_fault", fault, 0);
      n_reset = 1'b1;

      push(159, 161, 0, 0, 63);
      wait_valid(n);
      chk("first_latency", n, 965);
      push(159, 161, 1, 0, 63);
      wait_valid(n);
      chk("period_16", n, 960);
      push(159, 161, 1, 0, -1);
      wait_valid(n);

      half = 4;
      push(-1, -1, 0, 1, -1);
      wait_valid(n);
      push(119, 121, 0, 1, -1);
      wait_valid(n);
      chk("period_12", n, 960);

      half = 3;
      push(-1, -1, 0, 1, -1);
      wait_valid(n);
      push(159, 161, -1, 1, -1);
      wait_valid(n);
      push(159, 161, 1, 1, -1);
      wait_valid(n);

      half = 0;
      stuck = 1'b0;
      push(-1, -1, 0, 1, -1);
      wait_valid(n);
      push(0, 0, 0, 1, -1);
      wait_valid(n);
      chk("period_stuck0", n, 960);
      stuck = 1'b1;
      push(-1, -1, 0, 1, -1);
      wait_valid(n);
      push(0, 0, 0, 1, -1);
      wait_valid(n);
      chk("period_stuck1", n, 960);

      repeat (959) @(posedge clk);
      #1;
      clear_fault = 1'b1;
      push(0, 0, 0, 1, -1);
      wait_valid(n);
      chk("clr_same_cycle_lat", n, 1);
      @(posedge clk);
      #1;
      clear_fault = 1'b0;
      chk("clr_next_cycle", fault, 0);
      push(0, 0, 0, 1, -1);
      wait_valid(n);
      chk("period_after_clr", n, 959);

      half = 3;
      push(-1, -1, 0, 1, -1);
      wait_valid(n);
      push(159, 161, -1, 1, -1);
      wait_valid(n);
      push(159, 161, 1, 1, -1);
      wait_valid(n);

      repeat (500) @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("dis_freq_ok", freq_ok, 0);
      chk("dis_valid", valid, 0);
      chk("dis_fault_hold", fault, 1);
      chk_rng("dis_count_hold", count, 159, 161);
      seen = 1'b0;
      repeat (1500) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) seen = 1'b1;
      end
      chk("idle_no_valid", seen, 0);
      chk_rng("idle_count_hold", count, 159, 161);

      enable = 1'b1;
      push(159, 161, 0, 1, -1);
      wait_valid(n);
      chk("reenable_latency", n, 965);
      push(159, 161, 1, 1, -1);
      wait_valid(n);
      chk("reenable_period", n, 960);

      repeat (300) @(posedge clk);
      #1;
      n_reset = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_valid", valid, 0);
      chk("arst_freq_ok", freq_ok, 0);
      chk("arst_fault", fault, 0);
      chk("arst_sat_count", s_count, 0);
      chk("arst_sat_fault", s_fault, 0);
      repeat (2) @(posedge clk);
      #1;
      n_reset = 1'b1;
      push(159, 161, 0, 0, 63);
      wait_valid(n);
      chk("post_rst_latency", n, 965);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
